// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use, memory-wait and branch-flush stall controller
module hazard_stall_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       IF_ID_RS1_i,
  input  logic [4:0]       IF_ID_RS2_i,
  input  logic             ID_uses_rs1_i,
  input  logic             ID_uses_rs2_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RD_i,
  input  logic             EX_branch_taken_i,
  input  logic             MEM_req_i,
  input  logic             MEM_ready_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             ID_EX_bubble_o,
  output logic             IF_ID_flush_o,
  output logic             pipe_freeze_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       load_use, mem_wait;

  assign load_use = ID_EX_MemRead_i && (ID_EX_RD_i != 5'd0) &&
                    ((ID_uses_rs1_i && (ID_EX_RD_i == IF_ID_RS1_i)) ||
                     (ID_uses_rs2_i && (ID_EX_RD_i == IF_ID_RS2_i)));
  assign mem_wait = MEM_req_i && !MEM_ready_i;

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    PC_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    ID_EX_bubble_o = 1'b0;
    IF_ID_flush_o  = 1'b0;
    pipe_freeze_o  = 1'b0;

    case (state)
      RUN: begin
        if (mem_wait) begin
          pipe_freeze_o = 1'b1;
          wait_cnt_nxt  = 8'd1;
          state_nxt     = (TIMEOUT == 1) ? HALT : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          pipe_freeze_o = 1'b1;
          wait_cnt_nxt  = wait_cnt + 8'd1;
          if (wait_cnt == WAIT_LAST) state_nxt = HALT;
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end
      end
      HALT:    pipe_freeze_o = 1'b1;
      default: state_nxt = RUN;
    endcase

    // Freeze wins over flush, and a wrong-path ID instruction never needs a load-use stall
    if (pipe_freeze_o) begin
      PC_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
    end else if (EX_branch_taken_i) begin
      IF_ID_flush_o  = 1'b1;
      ID_EX_bubble_o = 1'b1;
    end else if (load_use) begin
      PC_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      ID_EX_bubble_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= RUN;
      wait_cnt      <= 8'd0;
      timeout_err_o <= 1'b0;
      stall_cnt_o   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == HALT) timeout_err_o <= 1'b1;
      if (!PC_write_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit (default and TIMEOUT=4/CNT_W=4)
module tb_hazard_stall_unit;

  localparam logic [4:0] NORM  = 5'b11000; // {pc_wr, ifid_wr, bubble, flush, freeze}
  localparam logic [4:0] STALL = 5'b00100;
  localparam logic [4:0] FLUSH = 5'b11110;
  localparam logic [4:0] FRZ   = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic u1 = 0, u2 = 0, mr = 0, br = 0, req = 0, rdy = 0;

  logic pcw, ifw, bub, fl, frz, err;
  logic [15:0] cnt;
  logic pcw_s, ifw_s, bub_s, fl_s, frz_s, err_s;
  logic [3:0] cnt_s;

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt = 0;
  int m_cnt_s = 0;

  typedef struct {
    string      tag;
    logic [4:0] ctrl;
    logic [4:0] ctrl_s;
    logic       err_s;
    int         cnt;
    int         cnt_s;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .IF_ID_RS1_i(rs1), .IF_ID_RS2_i(rs2),
    .ID_uses_rs1_i(u1), .ID_uses_rs2_i(u2),
    .ID_EX_MemRead_i(mr), .ID_EX_RD_i(rd),
    .EX_branch_taken_i(br), .MEM_req_i(req), .MEM_ready_i(rdy),
    .PC_write_o(pcw), .IF_ID_write_o(ifw), .ID_EX_bubble_o(bub),
    .IF_ID_flush_o(fl), .pipe_freeze_o(frz),
    .timeout_err_o(err), .stall_cnt_o(cnt)
  );

  hazard_stall_unit #(.TIMEOUT(4), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n),
    .IF_ID_RS1_i(rs1), .IF_ID_RS2_i(rs2),
    .ID_uses_rs1_i(u1), .ID_uses_rs2_i(u2),
    .ID_EX_MemRead_i(mr), .ID_EX_RD_i(rd),
    .EX_branch_taken_i(br), .MEM_req_i(req), .MEM_ready_i(rdy),
    .PC_write_o(pcw_s), .IF_ID_write_o(ifw_s), .ID_EX_bubble_o(bub_s),
    .IF_ID_flush_o(fl_s), .pipe_freeze_o(frz_s),
    .timeout_err_o(err_s), .stall_cnt_o(cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic a_u1,
                        input logic a_u2, input logic a_mr, input logic [4:0] a_rd,
                        input logic a_br, input logic a_req, input logic a_rdy);
    rs1 = a1; rs2 = a2; u1 = a_u1; u2 = a_u2; mr = a_mr; rd = a_rd;
    br = a_br; req = a_req; rdy = a_rdy;
  endtask

  // Push this cycle's expectations, then advance the model counters for the coming edge
  task automatic step(input string tag, input logic [4:0] ex, input logic [4:0] ex_s,
                      input logic e_err_s);
    exp_t e;
    e.tag = tag; e.ctrl = ex; e.ctrl_s = ex_s; e.err_s = e_err_s;
    e.cnt = m_cnt; e.cnt_s = m_cnt_s;
    sb.push_back(e);
    if (!ex[4] && m_cnt < 65535) m_cnt++;
    if (!ex_s[4] && m_cnt_s < 15) m_cnt_s++;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, "/ctrl"},   32'({pcw, ifw, bub, fl, frz}), 32'(e.ctrl));
      check({e.tag, "/ctrl_s"}, 32'({pcw_s, ifw_s, bub_s, fl_s, frz_s}), 32'(e.ctrl_s));
      check({e.tag, "/err"},    32'(err), 32'd0);
      check({e.tag, "/err_s"},  32'(err_s), 32'(e.err_s));
      check({e.tag, "/cnt"},    32'(cnt), 32'(e.cnt));
      check({e.tag, "/cnt_s"},  32'(cnt_s), 32'(e.cnt_s));
    end
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2;
    check("rst/ctrl", 32'({pcw, ifw, bub, fl, frz}), 32'(NORM));
    check("rst/err",  32'({err, err_s}), 32'd0);
    check("rst/cnt",  32'(cnt) + 32'(cnt_s), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("idle", NORM, NORM, 0);
    set_in(5, 0, 1, 0, 1, 5, 0, 0, 0); step("lu", STALL, STALL, 0);
    set_in(5, 0, 1, 0, 0, 5, 0, 0, 0); step("lu_after", NORM, NORM, 0);
    set_in(0, 0, 1, 0, 1, 0, 0, 0, 0); step("lu_rd0", NORM, NORM, 0);
    set_in(1, 5, 1, 0, 1, 5, 0, 0, 0); step("rs2_unused", NORM, NORM, 0);
    set_in(1, 5, 1, 1, 1, 5, 0, 0, 0); step("rs2_used", STALL, STALL, 0);
    set_in(5, 0, 1, 0, 1, 5, 1, 0, 0); step("br_vs_lu", FLUSH, FLUSH, 0);

    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step("mw", FRZ, FRZ, 0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); step("mw_ready", NORM, NORM, 0);

    set_in(5, 0, 1, 0, 1, 5, 1, 1, 0); step("frz_br_lu", FRZ, FRZ, 0);
    set_in(5, 0, 1, 0, 1, 5, 1, 1, 1); step("br_after_frz", FLUSH, FLUSH, 0);

    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step("mw2", FRZ, FRZ, 0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mw2_end", NORM, NORM, 0);

    for (int i = 0; i < 20; i++) begin
      set_in(7, 0, 1, 0, 1, 7, 0, 0, 0); step("sat_lu", STALL, STALL, 0);
      set_in(7, 0, 1, 0, 0, 7, 0, 0, 0); step("sat_nop", NORM, NORM, 0);
    end

    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step("to_wait", FRZ, FRZ, 0);
    end
    step("to_halt", FRZ, FRZ, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); step("to_ready", NORM, FRZ, 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step("to_br", FLUSH, FRZ, 1);

    #2 rst_n = 1'b0;
    #1;
    check("arst/ctrl",   32'({pcw, ifw, bub, fl, frz}), 32'(FLUSH));
    check("arst/ctrl_s", 32'({pcw_s, ifw_s, bub_s, fl_s, frz_s}), 32'(FLUSH));
    check("arst/err_s",  32'(err_s), 32'd0);
    check("arst/cnt",    32'(cnt), 32'd0);
    check("arst/cnt_s",  32'(cnt_s), 32'd0);
    m_cnt = 0; m_cnt_s = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("post_idle", NORM, NORM, 0);
    set_in(3, 0, 1, 0, 1, 3, 0, 0, 0); step("post_lu", STALL, STALL, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("post_end", NORM, NORM, 0);

    @(negedge clk); #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
